hazard_stall_controller: RTL



---
 rtl/hazard_stall_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Load-use / branch / memory-busy hazard controller for a 5-stage pipeline.
// Optional stall performance counter enabled by defining HAZARD_STALL_COUNT_EN.
//
// state | meaning
// IDLE  | no multi-cycle stall in progress; load-use hazards detected here
// STALL | extra load-latency bubbles being inserted, rem cycles left
module hazard_stall_controller #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rs,
  input  logic              ifid_uses_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_lat
    $error("hazard_stall_controller: LOAD_LAT must be within 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_stall_controller: CNT_W must be at least 1");
  end

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       haz;

  assign haz = idex_memread
             & ((ifid_uses_rs & (idex_rt == ifid_rs)) | (ifid_uses_rt & (idex_rt == ifid_rt)))
             & ~((ZERO_EXEMPT != 0) & (idex_rt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // A taken branch squashes any stall: the stalled instruction is wrong-path.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (mem_busy) begin
      state_nxt = state;
      rem_nxt   = rem;
    end else if (branch_taken) begin
      state_nxt = IDLE;
      rem_nxt   = 4'd0;
    end else if (state == STALL) begin
      rem_nxt = rem - 4'd1;
      if (rem == 4'd1) begin
        state_nxt = IDLE;
      end
    end else if (haz && (LOAD_LAT > 1)) begin
      state_nxt = STALL;
      rem_nxt   = REM_INIT;
    end
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_hold = 1'b0;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == STALL || haz) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pc_hold && !pipe_freeze && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
